// File: rtl/filtro_biquad_cascada_pkg.sv
// filtro_biquad_cascada_pkg: shared defaults, coefficient indices and FSM states
package filtro_biquad_cascada_pkg;
  localparam int N_DEF = 16;
  localparam int FRAC_DEF = 8;
  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;
  localparam logic [2:0] IDX_NUM = 3'd5;
  typedef enum logic {S_IDLE = 1'b0, S_CALC = 1'b1} state_e;
endpackage

// File: rtl/filtro_biquad_cascada_mac.sv
// filtro_biquad_cascada_mac: multiply-accumulate with round-to-nearest and saturation
module filtro_biquad_cascada_mac #(
  parameter int N = 16,
  parameter int FRAC = 8
) (
  input  logic signed [2*N+2:0] acc_i,
  input  logic signed [N-1:0]   coef_i,
  input  logic signed [N-1:0]   data_i,
  input  logic                  sub_i,
  output logic signed [2*N+2:0] acc_o,
  output logic signed [N-1:0]   sat_o
);
  localparam int AW = 2*N+3;
  localparam logic signed [AW-1:0] HI = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] LO = ~HI;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0] rnd;
  always_comb begin
    prod = coef_i * data_i;
    acc_o = sub_i ? acc_i - AW'(prod) : acc_i + AW'(prod);
    rnd = (acc_o + (AW'(1) <<< (FRAC-1))) >>> FRAC;
    sat_o = (rnd > HI) ? HI[N-1:0] : (rnd < LO) ? LO[N-1:0] : rnd[N-1:0];
  end
endmodule

// File: rtl/filtro_biquad_cascada.sv
// filtro_biquad_cascada: cascade of DF-II biquads sharing one MAC, five steps per section
module filtro_biquad_cascada
  import filtro_biquad_cascada_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int SECTIONS = 2,
  parameter int SEC_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 datolisto,
  input  logic [N-1:0]         uk,
  input  logic                 coef_we,
  input  logic [SEC_W+2:0]     coef_addr,
  input  logic [N-1:0]         coef_data,
  output logic [N-1:0]         yk,
  output logic                 resulisto,
  output logic                 ocupado,
  output logic                 perdido,
  output logic                 coef_err
);
  localparam int AW = 2*N+3;
  localparam int NS = 2**SEC_W;
  state_e state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d, w_sec;
  logic [2:0] step_q, step_d, w_idx;
  logic signed [AW-1:0] acc_q, acc_in, acc_o;
  logic signed [N-1:0] x_q, x_d, fn_q, fn_d, yk_q, yk_d, mac_c, mac_x, sat_o;
  logic signed [N-1:0] f1_q [NS];
  logic signed [N-1:0] f2_q [NS];
  logic signed [N-1:0] coef_q [NS][5];
  logic res_q, res_d, perd_q, err_q, wr_ok, last_sec;
  filtro_biquad_cascada_mac #(.N(N), .FRAC(FRAC)) u_mac (
    .acc_i(acc_in), .coef_i(mac_c), .data_i(mac_x), .sub_i(step_q < 3'd2),
    .acc_o(acc_o), .sat_o(sat_o)
  );
  always_comb begin
    w_sec = coef_addr[SEC_W+2:3];
    w_idx = coef_addr[2:0];
    wr_ok = coef_we && state_q == S_IDLE && !datolisto && w_idx < IDX_NUM && int'(w_sec) < SECTIONS;
    last_sec = int'(sec_q) == SECTIONS-1;
    acc_in = step_q == 3'd0 ? AW'(x_q) <<< FRAC : step_q == 3'd2 ? '0 : acc_q;
    mac_c = step_q == 3'd0 ? coef_q[sec_q][IDX_A1] : step_q == 3'd1 ? coef_q[sec_q][IDX_A2] :
            step_q == 3'd2 ? coef_q[sec_q][IDX_B0] : step_q == 3'd3 ? coef_q[sec_q][IDX_B1] :
            coef_q[sec_q][IDX_B2];
    mac_x = step_q == 3'd2 ? fn_q : (step_q == 3'd0 || step_q == 3'd3) ? f1_q[sec_q] : f2_q[sec_q];
    state_d = state_q;
    sec_d = sec_q;
    step_d = step_q;
    x_d = x_q;
    fn_d = fn_q;
    yk_d = yk_q;
    res_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (datolisto) begin
        state_d = S_CALC;
        x_d = uk;
        sec_d = '0;
        step_d = 3'd0;
      end
    end else begin
      step_d = step_q + 3'd1;
      if (step_q == 3'd1) fn_d = sat_o;
      if (step_q == 3'd4) begin
        x_d = sat_o;
        step_d = 3'd0;
        if (last_sec) begin
          state_d = S_IDLE;
          yk_d = sat_o;
          res_d = 1'b1;
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sec_q <= '0;
      step_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      fn_q <= '0;
      yk_q <= '0;
      res_q <= 1'b0;
      perd_q <= 1'b0;
      err_q <= 1'b0;
      for (int s = 0; s < NS; s++) begin
        f1_q[s] <= '0;
        f2_q[s] <= '0;
        for (int k = 0; k < 5; k++) coef_q[s][k] <= (k == int'(IDX_B0)) ? N'(1 << FRAC) : '0;
      end
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      step_q <= step_d;
      acc_q <= acc_o;
      x_q <= x_d;
      fn_q <= fn_d;
      yk_q <= yk_d;
      res_q <= res_d;
      perd_q <= datolisto && state_q == S_CALC;
      err_q <= coef_we && !wr_ok;
      if (state_q == S_CALC && step_q == 3'd4) begin
        f2_q[sec_q] <= f1_q[sec_q];
        f1_q[sec_q] <= fn_q;
      end
      if (wr_ok) coef_q[w_sec][w_idx] <= coef_data;
    end
  end
  assign yk = yk_q;
  assign resulisto = res_q;
  assign ocupado = state_q == S_CALC;
  assign perdido = perd_q;
  assign coef_err = err_q;
endmodule

// File: tb/tb_filtro_biquad_cascada.sv
// tb_filtro_biquad_cascada: directed vectors with hand-computed results for the two-section cascade
module tb_filtro_biquad_cascada;
  logic clk = 1'b0, reset = 1'b1, datolisto = 1'b0, coef_we = 1'b0;
  logic [15:0] uk = '0, coef_data = '0, yk;
  logic [4:0] coef_addr = '0;
  logic resulisto, ocupado, perdido, coef_err;
  int total = 0, passed = 0, n_res = 0, n_perd = 0, c = 0, n0 = 0;

  filtro_biquad_cascada #(.N(16), .FRAC(8), .SECTIONS(2), .SEC_W(2)) dut (
    .clk(clk), .reset(reset), .datolisto(datolisto), .uk(uk), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .yk(yk), .resulisto(resulisto),
    .ocupado(ocupado), .perdido(perdido), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (resulisto) n_res++;
    if (perdido) n_perd++;
  endtask

  task automatic send(input int u);
    datolisto = 1'b1;
    uk = 16'(u);
    tick();
    datolisto = 1'b0;
  endtask

  task automatic write(input int s, input int i, input int d);
    coef_we = 1'b1;
    coef_addr = 5'((s << 3) | i);
    coef_data = 16'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int exp, output int cyc);
    cyc = 0;
    while (resulisto !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_yk"}, int'($signed(yk)), exp);
  endtask

  task automatic run(input string tag, input int u, input int exp);
    int cyc;
    send(u);
    wait_res(tag, exp, cyc);
    chk({tag, "_lat"}, cyc, 10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_yk", int'(yk), 0);
    chk("rst_res", int'(resulisto), 0);
    chk("rst_ocup", int'(ocupado), 0);
    chk("rst_perd", int'(perdido), 0);
    chk("rst_err", int'(coef_err), 0);
    // pass-through after reset
    send(100);
    chk("t1_ocup", int'(ocupado), 1);
    wait_res("t1", 100, c);
    chk("t1_lat", c, 10);
    chk("t1_ocup_end", int'(ocupado), 0);
    tick();
    chk("t1_res_pulse", int'(resulisto), 0);
    run("t1b", -300, -300);
    // first-order section: w = x + 0.5 w1, y = 0.5 w + 0.25 w1; next sample sent during the pulse
    tick();
    do_reset();
    write(0, 0, 128);
    chk("t2_wr_ok", int'(coef_err), 0);
    write(0, 1, 64);
    write(0, 3, -128);
    run("t2a", 256, 128);
    run("t2b", 0, 128);
    run("t2c", 0, 64);
    // gain 2.0 saturates at both rails
    tick();
    do_reset();
    write(0, 0, 512);
    run("t3a", 20000, 32767);
    run("t3b", -20000, -32768);
    // dropped sample while busy
    tick();
    do_reset();
    n_perd = 0;
    send(77);
    tick();
    tick();
    datolisto = 1'b1;
    uk = 16'(999);
    tick();
    datolisto = 1'b0;
    chk("t4_perd", int'(perdido), 1);
    tick();
    chk("t4_perd_end", int'(perdido), 0);
    n0 = n_res;
    wait_res("t4", 77, c);
    chk("t4_lat", c, 6);
    for (int i = 0; i < 12; i++) tick();
    chk("t4_nres", n_res - n0, 1);
    chk("t4_nperd", n_perd, 1);
    // reset in the middle of a computation restores defaults
    write(0, 0, 512);
    send(123);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ocup", int'(ocupado), 0);
    chk("t5_yk", int'(yk), 0);
    chk("t5_res", int'(resulisto), 0);
    n0 = n_res;
    for (int i = 0; i < 15; i++) tick();
    chk("t5_nres", n_res - n0, 0);
    run("t5b", 50, 50);
    // rejected coefficient writes
    tick();
    send(40);
    tick();
    write(0, 0, 512);
    chk("t6_err_busy", int'(coef_err), 1);
    tick();
    chk("t6_err_pulse", int'(coef_err), 0);
    wait_res("t6a", 40, c);
    tick();
    write(0, 6, 512);
    chk("t6_err_idx", int'(coef_err), 1);
    write(3, 0, 512);
    chk("t6_err_sec", int'(coef_err), 1);
    datolisto = 1'b1;
    uk = 16'(40);
    coef_we = 1'b1;
    coef_addr = 5'd0;
    coef_data = 16'(512);
    tick();
    datolisto = 1'b0;
    coef_we = 1'b0;
    chk("t6_err_coinc", int'(coef_err), 1);
    chk("t6_ocup_coinc", int'(ocupado), 1);
    wait_res("t6b", 40, c);
    tick();
    run("t6c", -40, -40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
